// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard sequencer.
// The FSM encodings stay as plain localparams so legacy code can compare against them.
package pipeline_hazard_ctrl_pkg;

    // Mirrors `WORD_SIZE from opcodes.v.
    localparam int unsigned OPC_WORD_SIZE = 16;
    localparam int unsigned REG_ADDR_W    = 2;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic logic src_hit(input logic used, input reg_addr_t src, input reg_addr_t dst);
        return used & (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-status inputs from the datapath and the stage-register controls sent back to it.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE = OPC_WORD_SIZE
);
    reg_addr_t             id_rs;
    reg_addr_t             id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_halt;
    reg_addr_t             ex_rd;
    logic                  ex_mem_read;
    logic                  branch_taken;
    logic                  mem_busy;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  pipe_write;
    logic                  wb_valid;
    logic                  halted;
    logic [WORD_SIZE-1:0]  num_inst;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_halt, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_write, wb_valid,
               halted, num_inst
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_halt, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_write, wb_valid,
               halted, num_inst
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module pipeline_hazard_ctrl_load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic      ex_mem_read,
    input  logic      ex_valid,
    input  reg_addr_t ex_rd,
    input  logic      id_use_rs,
    input  reg_addr_t id_rs,
    input  logic      id_use_rt,
    input  reg_addr_t id_rt,
    output logic      load_use
);

    assign load_use = ex_mem_read & ex_valid &
                      (src_hit(id_use_rs, id_rs, ex_rd) | src_hit(id_use_rt, id_rt, ex_rd));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-cycle load/stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Also tracks stage valid bits and counts retired instructions.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = OPC_WORD_SIZE,
    parameter int unsigned FILL_CYCLES = 3
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned       FILL_W    = (FILL_CYCLES > 2) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic                 v_id_q, v_ex_q, v_mem_q, v_wb_q;
    logic                 v_id_d, v_ex_d, v_mem_d, v_wb_d;
    logic [WORD_SIZE-1:0] num_inst_q;

    logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_write, wb_valid;
    logic load_use;

    pipeline_hazard_ctrl_load_use_detect u_load_use_detect (
        .ex_mem_read (bus.ex_mem_read),
        .ex_valid    (v_ex_q),
        .ex_rd       (bus.ex_rd),
        .id_use_rs   (bus.id_use_rs),
        .id_rs       (bus.id_rs),
        .id_use_rt   (bus.id_use_rt),
        .id_rt       (bus.id_rt),
        .load_use    (load_use)
    );

    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_write  = 1'b0;
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;

        case (state_q)
            ST_FILL: begin
                fill_cnt_d = fill_cnt_q + FILL_W'(1);
                if (fill_cnt_q == FILL_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.mem_busy) begin
                    // Whole pipe freezes; nothing flushed.
                end else if (bus.branch_taken) begin
                    pc_write    = 1'b1;
                    pipe_write  = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    id_ex_flush = 1'b1;
                    pipe_write  = 1'b1;
                end else if (bus.id_halt && v_id_q) begin
                    if_id_flush = 1'b1;
                    pipe_write  = 1'b1;
                    state_d     = ST_DRAIN;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    pipe_write  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if_id_flush = 1'b1;
                pipe_write  = ~bus.mem_busy;
            end
            default: ;
        endcase

        v_id_d  = v_id_q;
        v_ex_d  = v_ex_q;
        v_mem_d = v_mem_q;
        v_wb_d  = v_wb_q;
        if (pipe_write) begin
            v_wb_d  = v_mem_q;
            v_mem_d = v_ex_q;
            v_ex_d  = v_id_q & ~id_ex_flush;
            if (if_id_flush)      v_id_d = 1'b0;
            else if (if_id_write) v_id_d = 1'b1;
        end

        if (state_q == ST_DRAIN && !(v_ex_d || v_mem_d || v_wb_d)) state_d = ST_HALTED;

        // Reset overrides everything so the datapath registers clear to bubbles.
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_write  = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign wb_valid = v_wb_q & ~bus.mem_busy & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
            v_id_q     <= 1'b0;
            v_ex_q     <= 1'b0;
            v_mem_q    <= 1'b0;
            v_wb_q     <= 1'b0;
            num_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            v_id_q     <= v_id_d;
            v_ex_q     <= v_ex_d;
            v_mem_q    <= v_mem_d;
            v_wb_q     <= v_wb_d;
            if (wb_valid) num_inst_q <= num_inst_q + WORD_SIZE'(1);
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.if_id_write = if_id_write;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.pipe_write  = pipe_write;
    assign bus.wb_valid    = wb_valid;
    assign bus.halted      = (state_q == ST_HALTED) & ~reset;
    assign bus.num_inst    = num_inst_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: warm-up, load-use, branch squash, memory stall,
// halt drain and reset during drain. Control word is {pc, if_id_wr, if_id_fl, id_ex_fl, pipe}.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipeline_hazard_ctrl_if #(.WORD_SIZE(16)) bus ();

    pipeline_hazard_ctrl #(
        .WORD_SIZE   (16),
        .FILL_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [4:0] ctrl;
    assign ctrl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                   bus.pipe_write};

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_RST   = 5'b00110;
    localparam logic [4:0] C_RUN   = 5'b11001;
    localparam logic [4:0] C_LU    = 5'b00011;
    localparam logic [4:0] C_BR    = 5'b10111;
    localparam logic [4:0] C_HALT  = 5'b00101;
    localparam logic [4:0] C_DBUSY = 5'b00100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_use_rs    = 1'b0;
        bus.id_use_rt    = 1'b0;
        bus.id_halt      = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_mem_read  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_busy     = 1'b0;
    endtask

    // Two reset cycles, three fill cycles, ending settled in the first RUN cycle.
    task automatic do_reset(input string tag);
        clr();
        reset = 1'b1;
        settle();
        check({tag, "_rst_ctrl"}, 32'(ctrl), 32'(C_RST));
        check({tag, "_rst_halted"}, 32'(bus.halted), 32'd0);
        check({tag, "_rst_wb"}, 32'(bus.wb_valid), 32'd0);
        next();
        next();
        reset = 1'b0;
        settle();
        check({tag, "_fill0"}, 32'(ctrl), 32'(C_IDLE));
        check({tag, "_fill0_num"}, 32'(bus.num_inst), 32'd0);
        next(); settle();
        check({tag, "_fill1"}, 32'(ctrl), 32'(C_IDLE));
        next(); settle();
        check({tag, "_fill2"}, 32'(ctrl), 32'(C_IDLE));
        next(); settle();
        check({tag, "_first_fetch"}, 32'(ctrl), 32'(C_RUN));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr();
        reset = 1'b0;

        // Load-use stall via rs, then no stall when rs is not read, then via rt.
        do_reset("a");
        next(); settle();
        check("a_r2", 32'(ctrl), 32'(C_RUN));
        next();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 2'd1; bus.id_rs = 2'd1; bus.id_use_rs = 1'b1;
        settle();
        check("a_lu_rs", 32'(ctrl), 32'(C_LU));
        next(); settle();
        check("a_one_bubble", 32'(ctrl), 32'(C_RUN));
        next();
        bus.id_use_rs = 1'b0;
        settle();
        check("a_no_use", 32'(ctrl), 32'(C_RUN));
        check("a_wb_r5", 32'(bus.wb_valid), 32'd1);
        check("a_num_r5", 32'(bus.num_inst), 32'd0);
        next();
        bus.id_use_rt = 1'b1; bus.id_rt = 2'd1;
        settle();
        check("a_lu_rt", 32'(ctrl), 32'(C_LU));
        check("a_num_r6", 32'(bus.num_inst), 32'd1);

        // Branch squashes a simultaneous halt and load-use; two bubbles reach WB.
        next();
        do_reset("b");
        next(); settle();
        check("b_r2", 32'(ctrl), 32'(C_RUN));
        next();
        bus.branch_taken = 1'b1; bus.id_halt = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 2'd2; bus.id_rt = 2'd2; bus.id_use_rt = 1'b1;
        settle();
        check("b_branch", 32'(ctrl), 32'(C_BR));
        next(); clr(); settle();
        check("b_still_run", 32'(ctrl), 32'(C_RUN));
        next(); settle();
        check("b_wb_branch", 32'(bus.wb_valid), 32'd1);
        next(); settle();
        check("b_bubble1", 32'(bus.wb_valid), 32'd0);
        next(); settle();
        check("b_bubble2", 32'(bus.wb_valid), 32'd0);
        next(); settle();
        check("b_wb_after", 32'(bus.wb_valid), 32'd1);
        check("b_num", 32'(bus.num_inst), 32'd1);

        // Four-cycle memory stall, with a branch arriving mid-stall.
        bus.mem_busy = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) begin
            bus.branch_taken = (i == 1);
            settle();
            check("c_busy_ctrl", 32'(ctrl), 32'(C_IDLE));
            check("c_busy_wb", 32'(bus.wb_valid), 32'd0);
            check("c_busy_num", 32'(bus.num_inst), 32'd1);
            next();
        end
        clr();
        settle();
        check("c_resume_ctrl", 32'(ctrl), 32'(C_RUN));
        check("c_resume_wb", 32'(bus.wb_valid), 32'd1);
        next(); settle();
        check("c_resume_num", 32'(bus.num_inst), 32'd2);

        // Five ADDs then HLT; halted four cycles after HLT sits in ID.
        next();
        do_reset("d");
        for (int i = 2; i <= 6; i++) begin
            next(); settle();
            check("d_add", 32'(ctrl), 32'(C_RUN));
        end
        next();
        bus.id_halt = 1'b1;
        settle();
        check("d_hlt_id", 32'(ctrl), 32'(C_HALT));
        check("d_num_r7", 32'(bus.num_inst), 32'd2);
        next();
        bus.id_halt = 1'b0;
        settle();
        check("d_drain1", 32'(ctrl), 32'(C_HALT));
        check("d_not_halted", 32'(bus.halted), 32'd0);
        next();
        bus.branch_taken = 1'b1;
        settle();
        check("d_drain2_br_ignored", 32'(ctrl), 32'(C_HALT));
        next(); clr(); settle();
        check("d_drain3", 32'(ctrl), 32'(C_HALT));
        check("d_hlt_wb", 32'(bus.wb_valid), 32'd1);
        check("d_num_r10", 32'(bus.num_inst), 32'd5);
        next(); settle();
        check("d_halted", 32'(bus.halted), 32'd1);
        check("d_halted_ctrl", 32'(ctrl), 32'(C_IDLE));
        check("d_num_final", 32'(bus.num_inst), 32'd6);
        next(); settle();
        check("d_halted_hold", 32'(bus.halted), 32'd1);
        check("d_pc_hold", 32'(bus.pc_write), 32'd0);

        // Reset out of HALTED clears the count; then reset again while draining.
        next();
        do_reset("e");
        next();
        bus.id_halt = 1'b1;
        settle();
        check("e_hlt_id", 32'(ctrl), 32'(C_HALT));
        next();
        clr();
        bus.mem_busy = 1'b1;
        settle();
        check("e_drain_busy", 32'(ctrl), 32'(C_DBUSY));
        next();
        do_reset("e2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
